// File: rtl/ides4_bitslip_align.sv
// Word-alignment controller behind the IDES4 4:1 deserializer: bit-slips until q_in shows PATTERN, then locks.
// Optional `define IDES4_ALIGN_SLIPCNT_EN adds slip_count/rotation diagnostic outputs.
module ides4_bitslip_align #(
  parameter logic [3:0] PATTERN       = 4'b1100,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         MATCH_COUNT   = 16,
  parameter int         MAX_SLIPS     = 8
) (
  input  logic       PCLK,
  input  logic       RESET,
  input  logic       start,
  input  logic [3:0] q_in,
  output logic       CALIB,
  output logic       locked,
  output logic       fail,
  output logic [3:0] dout,
  output logic       dout_valid
`ifdef IDES4_ALIGN_SLIPCNT_EN
  ,
  output logic [3:0] slip_count,
  output logic [1:0] rotation
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int PW = $clog2(MAX_SLIPS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_LOCKED,
    S_FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [MW-1:0] match_q, match_d;
  logic [PW-1:0] slip_q, slip_d;
  logic          calib_q, locked_q, fail_q, dout_valid_q;
  logic [3:0]    dout_q;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d  = state_q;
    settle_d = settle_q;
    match_d  = match_q;
    slip_d   = slip_q;
    if (start) begin
      state_d  = S_SETTLE;
      settle_d = '0;
      match_d  = '0;
      slip_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_SETTLE: begin
          // q_in is still flushing through the deserializer here and is ignored
          if (settle_q >= SW'(SETTLE_CYCLES - 1)) begin
            settle_d = '0;
            state_d  = S_CHECK;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (q_in == PATTERN) begin
            if (match_q < MW'(MATCH_COUNT)) match_d = match_q + 1'b1;
            if (match_q >= MW'(MATCH_COUNT - 1)) state_d = S_LOCKED;
          end else begin
            match_d = '0;
            state_d = (slip_q < PW'(MAX_SLIPS)) ? S_SLIP : S_FAIL;
          end
        end
        S_SLIP: begin
          if (slip_q < PW'(MAX_SLIPS)) slip_d = slip_q + 1'b1;
          state_d = S_SETTLE;
        end
        S_LOCKED: ;
        S_FAIL: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      settle_q     <= '0;
      match_q      <= '0;
      slip_q       <= '0;
      calib_q      <= 1'b0;
      locked_q     <= 1'b0;
      fail_q       <= 1'b0;
      dout_q       <= 4'b0000;
      dout_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      settle_q     <= settle_d;
      match_q      <= match_d;
      slip_q       <= slip_d;
      // Outputs decode the next state, so each is high exactly while its state is current
      calib_q      <= (state_d == S_SLIP);
      locked_q     <= (state_d == S_LOCKED);
      fail_q       <= (state_d == S_FAIL);
      dout_q       <= q_in;
      dout_valid_q <= !start && (state_q == S_LOCKED);
    end
  end

  assign CALIB      = calib_q;
  assign locked     = locked_q;
  assign fail       = fail_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`ifdef IDES4_ALIGN_SLIPCNT_EN
  logic [3:0] slip_ext_d;
  logic [1:0] rotation_q;

  assign slip_ext_d = 4'(slip_d);

  // Rotation follows the slip count during training and freezes once locked
  always_ff @(posedge PCLK) begin
    if (RESET) begin
      rotation_q <= 2'b00;
    end else if (start || state_q != S_LOCKED) begin
      rotation_q <= slip_ext_d[1:0];
    end
  end

  assign slip_count = 4'(slip_q);
  assign rotation   = rotation_q;
`endif

endmodule

// File: doc/ides4_bitslip_align.md
Name: ides4_bitslip_align

Overview:
- PCLK-domain word-alignment controller directly downstream of the IDES4 4:1 deserializer.
- Consumes the 4-bit parallel word each PCLK cycle and compares it against a known repeating training pattern.
- Issues single-cycle CALIB (bit-slip) pulses back to the deserializer until the word boundary matches, then declares lock and forwards aligned data.
- Sits between the per-lane deserializer and the correlator input.

Parameters:
PATTERN, 4'b1100, training word expected at q_in once aligned; all four rotations must be distinct
SETTLE_CYCLES, 4, PCLK cycles to ignore q_in after a CALIB pulse or start (deserializer pipeline flush); must be >= 1
MATCH_COUNT, 16, consecutive matching words required to declare lock; must be >= 1
MAX_SLIPS, 8, CALIB pulses allowed per training attempt before declaring failure

Ports:
PCLK  input  1  primary (slow) clock; the only clock
RESET  input  1  synchronous active-high reset
start  input  1  one-cycle request to begin or restart training
q_in  input  4  deserialized word {Q0,Q1,Q2,Q3}; q_in[3] is the earliest received bit
CALIB  output  1  bit-slip pulse to the deserializer, one PCLK cycle wide
locked  output  1  alignment achieved; held until start or RESET
fail  output  1  MAX_SLIPS exhausted without lock; held until start or RESET
dout  output  4  aligned data word, registered copy of q_in
dout_valid  output  1  dout is valid (registered locked qualifier)

Behaviour:
- Reset: state IDLE; CALIB, locked, fail, dout_valid = 0; dout = 4'b0000; all counters = 0.
- Priority: RESET > start > state logic. A start pulse in any state clears the slip, match and settle counters, forces CALIB = 0, locked = 0, fail = 0, and enters SETTLE on the next cycle.
- IDLE: outputs quiescent; waits for start.
- SETTLE: settle counter runs from 0 to SETTLE_CYCLES-1; q_in is ignored; then go to CHECK.
- CHECK: each cycle compares q_in with PATTERN.
  - Match: match counter +1. When it reaches MATCH_COUNT, go to LOCKED; locked is registered high on that transition.
  - Mismatch: match counter is cleared. If slip counter < MAX_SLIPS, go to SLIP; otherwise go to FAIL.
- SLIP: CALIB = 1 for exactly this cycle; slip counter +1; next state SETTLE. CALIB can never be high on two consecutive cycles.
- LOCKED: locked = 1; q_in is no longer compared, so payload data may differ from PATTERN. Exit only via start or RESET.
- FAIL: fail = 1, CALIB = 0. Exit only via start or RESET.
- Data path: dout <= q_in every cycle (one-cycle latency). dout_valid <= (state == LOCKED), so the first valid dout is the word sampled in the first LOCKED cycle.
- Counter widths: $clog2(MAX+1) of the respective limit; counters saturate and never wrap.
- Timing with aligned input (zero slips): start at cycle 0 -> SETTLE cycles 1..SETTLE_CYCLES -> CHECK cycles SETTLE_CYCLES+1 .. SETTLE_CYCLES+MATCH_COUNT -> locked = 1 at cycle SETTLE_CYCLES+MATCH_COUNT+1 (cycle 21 with defaults).
- Each slip adds 1 (SLIP) + SETTLE_CYCLES cycles plus the CHECK cycles spent before the failing mismatch.
- RESET asserted mid-training: next cycle all outputs are at reset values. A CALIB pulse already in flight is dropped.

Optional Feature:
- Macro: IDES4_ALIGN_SLIPCNT_EN.
- When defined:
  - Adds output port slip_count, width 4. It holds the number of CALIB pulses issued in the current attempt, cleared on start and RESET.
  - Adds output port rotation, width 2. It is slip_count modulo 4, frozen when locked rises, for lane-skew diagnostics.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Aligned stream: RESET, start, q_in held at 4'b1100 -> no CALIB pulses; locked = 1 at cycle 21 after start; dout_valid = 1 one cycle later with dout = 4'b1100.
- Misaligned stream: q_in = 4'b0110 until each CALIB pulse, rotating one position per pulse (0110 -> 0011 -> 1001 -> 1100) after SETTLE_CYCLES -> exactly 3 single-cycle CALIB pulses, then locked. With the feature enabled, slip_count = 3 and rotation = 3.
- Never-matching input: q_in held at 4'b0000 -> 8 CALIB pulses, each separated by >= 5 cycles, then fail = 1, locked = 0, CALIB stays 0.
- Glitch during CHECK: aligned stream with one 4'b1111 word injected after 10 matches -> match counter cleared, one CALIB pulse issued, locked not asserted before 16 further consecutive matches.
- Restart and reset: start pulsed while LOCKED -> locked and dout_valid drop the next cycle and SETTLE is re-entered. RESET asserted in the same cycle as a CALIB pulse -> next cycle all outputs are 0 and state is IDLE. start and RESET asserted together -> IDLE.
